ren_map: RTL and testbench

REN_MAP -- requirements
Module: ren_map

---
 rtl/ren_map_pkg.sv | 33 +++
 rtl/ren_freelist.sv | 84 ++++++++
 rtl/ren_map.sv | 127 ++++++++++++
 tb/tb_ren_map.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ren_map_pkg.sv
// Shared constants and types for the register renamer: register counts,
// specifier widths and the layout of the 26-bit push-data word.
package ren_map_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;

    localparam int AREG_W = 5;
    localparam int PREG_W = 6;
    localparam int PTR_W  = 5;
    localparam int CNT_W  = 6;
    localparam int PUSH_W = 26;

    // Bit offsets of each field inside the push-data word.
    localparam int SRC1_LSB      = 0;
    localparam int SRC2_LSB      = 6;
    localparam int DEST_LSB      = 12;
    localparam int OLD_DEST_LSB  = 18;
    localparam int NEED_DEST_BIT = 24;
    localparam int IS_MEM_BIT    = 25;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic  is_mem;
        logic  need_dest;
        preg_t old_dest;
        preg_t dest;
        preg_t src2;
        preg_t src1;
    } push_data_t;

endpackage

// File: rtl/ren_freelist.sv
// Circular FIFO of free physical registers; a push into a full list with no
// concurrent pop is dropped and raises a sticky overflow flag.
module ren_freelist #(
    parameter int ARCH_REGS = ren_map_pkg::ARCH_REGS,
    parameter int PHYS_REGS = ren_map_pkg::PHYS_REGS
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         push_i,
    input  ren_map_pkg::preg_t           push_reg_i,
    input  logic                         pop_i,
    output ren_map_pkg::preg_t           head_reg_o,
    output logic [ren_map_pkg::CNT_W-1:0] count_o,
    output logic                         overflow_o
);
    import ren_map_pkg::*;

    localparam int                 DEPTH    = PHYS_REGS - ARCH_REGS;
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    preg_t              mem_q [DEPTH];
    preg_t              mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               do_pop, do_push;

    assign head_reg_o = mem_q[head_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        do_pop  = pop_i && (count_q != '0);
        // A pop in the same cycle frees the slot the push needs.
        do_push = push_i && ((count_q != FULL_CNT) || do_pop);

        if (do_pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
        end
        if (do_push) begin
            mem_d[tail_q] = push_reg_i;
            tail_d        = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
        end
        if (push_i && !do_push) begin
            overflow_d = 1'b1;
        end

        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: the list storage is reset because its contents are architecturally
    // defined after reset (the initial pool of free registers).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preg_t'(ARCH_REGS + i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= FULL_CNT;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/ren_map.sv
// Register rename stage: map table, free-list allocation and one-cycle push to IQ/LSQ.
// Optional feature macro: REN_COMMIT_BYPASS_EN (hand a committing register straight to an empty-list rename).
module ren_map #(
    parameter int ARCH_REGS = ren_map_pkg::ARCH_REGS,
    parameter int PHYS_REGS = ren_map_pkg::PHYS_REGS
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           FREEZE,
    input  logic                           ID_valid_IN,
    input  logic [ren_map_pkg::AREG_W-1:0] ID_src1_IN,
    input  logic [ren_map_pkg::AREG_W-1:0] ID_src2_IN,
    input  logic [ren_map_pkg::AREG_W-1:0] ID_dest_IN,
    input  logic                           ID_needDest_IN,
    input  logic                           ID_isMem_IN,
    output logic                           ID_stall_OUT,
    input  logic                           IQ_full_IN,
    input  logic                           LSQ_full_IN,
    output logic                           IQ_pushReq_OUT,
    output logic                           LSQ_pushReq_OUT,
    output logic [ren_map_pkg::PUSH_W-1:0] REN_pushData_OUT,
    input  logic                           COM_valid_IN,
    input  logic [ren_map_pkg::PREG_W-1:0] COM_freeReg_IN,
    output logic                           REN_overflow_OUT
);
    import ren_map_pkg::*;

    preg_t              map_q [ARCH_REGS];
    preg_t              map_d [ARCH_REGS];
    push_data_t         pd_q, pd_d;
    logic               iq_push_q, iq_push_d;
    logic               lsq_push_q, lsq_push_d;

    logic               eff_need_dest;
    logic               target_full;
    logic               list_empty;
    logic               bypass_avail;
    logic               bypass_take;
    logic               no_dest_reg;
    logic               accept;
    logic               fl_push, fl_pop;
    preg_t              fl_head;
    logic [CNT_W-1:0]   fl_count;
    logic               fl_overflow;
    preg_t              new_dest;

    ren_freelist #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_freelist (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_i     (fl_push),
        .push_reg_i (COM_freeReg_IN),
        .pop_i      (fl_pop),
        .head_reg_o (fl_head),
        .count_o    (fl_count),
        .overflow_o (fl_overflow)
    );

    always_comb begin
        eff_need_dest = ID_needDest_IN && (ID_dest_IN != '0);
        target_full   = ID_isMem_IN ? LSQ_full_IN : IQ_full_IN;
        list_empty    = (fl_count == '0);
`ifdef REN_COMMIT_BYPASS_EN
        bypass_avail  = COM_valid_IN;
`else
        bypass_avail  = 1'b0;
`endif
        no_dest_reg   = eff_need_dest && list_empty && !bypass_avail;
        accept        = ID_valid_IN && !FREEZE && !target_full && !no_dest_reg;
        bypass_take   = accept && eff_need_dest && list_empty && bypass_avail;
        ID_stall_OUT  = ID_valid_IN && !accept;

        fl_pop   = accept && eff_need_dest && !bypass_take;
        fl_push  = COM_valid_IN && !FREEZE && !bypass_take;
        new_dest = bypass_take ? COM_freeReg_IN : fl_head;
    end

    always_comb begin
        map_d      = map_q;
        pd_d       = pd_q;
        iq_push_d  = 1'b0;
        lsq_push_d = 1'b0;

        if (accept) begin
            // Sources read map_q, so a source equal to dest sees the old mapping.
            pd_d.src1      = map_q[ID_src1_IN];
            pd_d.src2      = map_q[ID_src2_IN];
            pd_d.is_mem    = ID_isMem_IN;
            pd_d.need_dest = eff_need_dest;
            pd_d.dest      = '0;
            pd_d.old_dest  = '0;
            if (eff_need_dest) begin
                pd_d.dest             = new_dest;
                pd_d.old_dest         = map_q[ID_dest_IN];
                map_d[ID_dest_IN]     = new_dest;
            end
            iq_push_d  = !ID_isMem_IN;
            lsq_push_d = ID_isMem_IN;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= preg_t'(i);
            end
            pd_q       <= '0;
            iq_push_q  <= 1'b0;
            lsq_push_q <= 1'b0;
        end else begin
            map_q      <= map_d;
            pd_q       <= pd_d;
            iq_push_q  <= iq_push_d;
            lsq_push_q <= lsq_push_d;
        end
    end

    assign IQ_pushReq_OUT   = iq_push_q;
    assign LSQ_pushReq_OUT  = lsq_push_q;
    assign REN_pushData_OUT = pd_q;
    assign REN_overflow_OUT = fl_overflow;

endmodule

// File: tb/tb_ren_map.sv
// Self-checking bench for ren_map: directed scenarios then random traffic,
// compared against a map-array / free-queue reference model.
module tb_ren_map;

    localparam int ARCH = 32;
    localparam int PHYS = 64;
    localparam int DEPTH = PHYS - ARCH;

    logic        CLK = 1'b0;
    logic        RESET, FREEZE;
    logic        ID_valid_IN, ID_needDest_IN, ID_isMem_IN;
    logic [4:0]  ID_src1_IN, ID_src2_IN, ID_dest_IN;
    logic        ID_stall_OUT;
    logic        IQ_full_IN, LSQ_full_IN;
    logic        IQ_pushReq_OUT, LSQ_pushReq_OUT;
    logic [25:0] REN_pushData_OUT;
    logic        COM_valid_IN;
    logic [5:0]  COM_freeReg_IN;
    logic        REN_overflow_OUT;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int          map_m [ARCH];
    int          fl_m [$];
    logic        ovf_m;
    logic [25:0] pd_m;
    logic        iq_m, lsq_m;

    always #5 CLK = ~CLK;

    ren_map dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .FREEZE           (FREEZE),
        .ID_valid_IN      (ID_valid_IN),
        .ID_src1_IN       (ID_src1_IN),
        .ID_src2_IN       (ID_src2_IN),
        .ID_dest_IN       (ID_dest_IN),
        .ID_needDest_IN   (ID_needDest_IN),
        .ID_isMem_IN      (ID_isMem_IN),
        .ID_stall_OUT     (ID_stall_OUT),
        .IQ_full_IN       (IQ_full_IN),
        .LSQ_full_IN      (LSQ_full_IN),
        .IQ_pushReq_OUT   (IQ_pushReq_OUT),
        .LSQ_pushReq_OUT  (LSQ_pushReq_OUT),
        .REN_pushData_OUT (REN_pushData_OUT),
        .COM_valid_IN     (COM_valid_IN),
        .COM_freeReg_IN   (COM_freeReg_IN),
        .REN_overflow_OUT (REN_overflow_OUT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARCH; i++) map_m[i] = i;
        fl_m.delete();
        for (int p = ARCH; p < PHYS; p++) fl_m.push_back(p);
        ovf_m = 1'b0;
        pd_m  = '0;
        iq_m  = 1'b0;
        lsq_m = 1'b0;
    endtask

    function automatic logic eff_need();
        return ID_needDest_IN && (ID_dest_IN != 0);
    endfunction

    function automatic logic bypass_ok();
`ifdef REN_COMMIT_BYPASS_EN
        return COM_valid_IN;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_accept();
        logic full_sel;
        logic starved;
        full_sel = ID_isMem_IN ? LSQ_full_IN : IQ_full_IN;
        starved  = eff_need() && (fl_m.size() == 0) && !bypass_ok();
        return ID_valid_IN && !FREEZE && !full_sel && !starved;
    endfunction

    task automatic model_update();
        logic       acc, taken;
        logic [5:0] s1, s2, nd, od;
        if (RESET) begin
            model_reset();
            return;
        end
        acc   = model_accept();
        taken = 1'b0;
        if (acc) begin
            s1 = 6'(map_m[ID_src1_IN]);
            s2 = 6'(map_m[ID_src2_IN]);
            nd = '0;
            od = '0;
            if (eff_need()) begin
                if (fl_m.size() == 0) begin
                    nd    = COM_freeReg_IN;
                    taken = 1'b1;
                end else begin
                    nd = 6'(fl_m.pop_front());
                end
                od = 6'(map_m[ID_dest_IN]);
                map_m[ID_dest_IN] = nd;
            end
            pd_m  = {ID_isMem_IN, eff_need(), od, nd, s2, s1};
            iq_m  = !ID_isMem_IN;
            lsq_m = ID_isMem_IN;
        end else begin
            iq_m  = 1'b0;
            lsq_m = 1'b0;
        end
        if (COM_valid_IN && !FREEZE && !taken) begin
            if (fl_m.size() < DEPTH) fl_m.push_back(COM_freeReg_IN);
            else ovf_m = 1'b1;
        end
    endtask

    // One clock: check combinational stall, advance, check registered outputs.
    task automatic step();
        #1;
        check("stall", ID_stall_OUT, ID_valid_IN && !model_accept());
        @(posedge CLK);
        model_update();
        #1;
        check("iq_push", IQ_pushReq_OUT, iq_m);
        check("lsq_push", LSQ_pushReq_OUT, lsq_m);
        check("push_data", REN_pushData_OUT, pd_m);
        check("overflow", REN_overflow_OUT, ovf_m);
    endtask

    task automatic set_id(input logic v, input int d, input int a, input int b,
                          input logic need, input logic mem);
        ID_valid_IN    = v;
        ID_dest_IN     = 5'(d);
        ID_src1_IN     = 5'(a);
        ID_src2_IN     = 5'(b);
        ID_needDest_IN = need;
        ID_isMem_IN    = mem;
    endtask

    task automatic set_com(input logic v, input int r);
        COM_valid_IN   = v;
        COM_freeReg_IN = 6'(r);
    endtask

    initial begin
        RESET = 1'b1; FREEZE = 1'b0; IQ_full_IN = 1'b0; LSQ_full_IN = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        set_com(0, 0);
        model_reset();

        // Reset state
        step(); step();
        RESET = 1'b0;

        // Basic rename into IQ
        set_id(1, 5, 5, 6, 1, 0);
        step();
        check("first_dest", REN_pushData_OUT[17:12], 32'd32);
        check("first_old", REN_pushData_OUT[23:18], 32'd5);
        set_id(0, 0, 0, 0, 0, 0);
        step();

        // Drain the free list: 32 accepts then a stall
        RESET = 1'b1; step(); RESET = 1'b0;
        for (int i = 0; i < 33; i++) begin
            set_id(1, (i % 31) + 1, i % 32, (i + 3) % 32, 1, i[0]);
            step();
        end
        check("drained_stall", ID_stall_OUT, 1'b1);
        set_com(1, 7);
        step();
`ifdef REN_COMMIT_BYPASS_EN
        check("bypass_dest", REN_pushData_OUT[17:12], 32'd7);
`endif
        set_com(0, 0);
        step();
`ifndef REN_COMMIT_BYPASS_EN
        check("refill_dest", REN_pushData_OUT[17:12], 32'd7);
`endif

        // Full target queue routing
        RESET = 1'b1; step(); RESET = 1'b0;
        LSQ_full_IN = 1'b1;
        set_id(1, 9, 1, 2, 1, 1);
        step();
        set_id(1, 9, 9, 2, 1, 0);
        step();
        LSQ_full_IN = 1'b0;
        IQ_full_IN  = 1'b1;
        set_id(1, 4, 9, 4, 1, 0);
        step();
        IQ_full_IN  = 1'b0;

        // Destination zero is never renamed
        set_id(1, 0, 9, 0, 1, 1);
        step();
        set_id(1, 10, 9, 10, 1, 0);
        step();

        // Freeze holds everything
        FREEZE = 1'b1;
        set_com(1, 3);
        set_id(1, 11, 1, 1, 1, 0);
        step(); step();
        FREEZE = 1'b0;
        set_com(0, 0);
        step();

        // Overflow on a full list, sticky until reset
        RESET = 1'b1; set_id(0, 0, 0, 0, 0, 0); step(); RESET = 1'b0;
        set_com(1, 40);
        step();
        set_com(0, 0);
        step(); step();
        check("ovf_sticky", REN_overflow_OUT, 1'b1);

        // Reset in the middle of a rename stream
        set_id(1, 12, 3, 4, 1, 1);
        step();
        RESET = 1'b1;
        set_id(1, 13, 12, 13, 1, 0);
        step();
        check("reset_no_push", IQ_pushReq_OUT, 1'b0);
        RESET = 1'b0;
        set_id(1, 12, 12, 13, 1, 0);
        step();
        check("reset_map_id", REN_pushData_OUT[23:18], 32'd12);
        check("reset_count", REN_pushData_OUT[17:12], 32'd32);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            RESET       = ($urandom_range(0, 99) == 0);
            FREEZE      = ($urandom_range(0, 15) == 0);
            IQ_full_IN  = ($urandom_range(0, 7) == 0);
            LSQ_full_IN = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            set_com($urandom_range(0, 2) == 0, $urandom_range(0, 63));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
